ram_bist_ctrl: RTL and testbench
================================

// Module: ram_bist_ctrl
// PURPOSE
//  Upstream controller for the ram_3 1024x8 single-port RAM. On a start pulse it
//  fills every location with a deterministic pattern, reads every location back,
//  and compares each read against the expected value. It reports pass/fail, the
//  first failing address and a saturating error count. It owns the RAM's address,
//  data_in, write and select pins for the whole self-test.
// PARAMETERS
//  AW      10  address width; DEPTH = 2**AW locations
//  DW       8  data width
//  SEED     0  pattern offset: pattern(a) = (2*a + SEED) mod 2**DW
//  RD_LAT   1  cycles from read address presented to ram_dout valid (0 or 1)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   begin test; sampled only in IDLE
//  invert       in   1   sampled with start; 1 = use ~pattern(a) for the whole run
//  ram_addr     out  AW  RAM address
//  ram_din      out  DW  RAM write data
//  ram_write    out  1   RAM write strobe, active-high
//  ram_select   out  1   RAM chip select, active-high
//  ram_dout     in   DW  RAM read data
//  busy         out  1   high from cycle after start until done
//  done         out  1   one-cycle pulse at end of test
//  pass         out  1   valid from done until next start; 1 = zero errors
//  fail_addr    out  AW  address of first miscompare (0 if none)
//  err_count    out  8   miscompare count, saturates at 255
// BEHAVIOUR
//  - Reset: every output is 0 and the state is IDLE. Reset asserted mid-run aborts
//    immediately; no partial result is kept.
//  - FSM: IDLE -> FILL -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: ram_select=0, ram_write=0. If start=1 at a clock edge, latch invert,
//    clear err_count, fail_addr and pass, and go to FILL with address 0.
//  - FILL: one write per cycle for a=0..DEPTH-1, with ram_select=1, ram_write=1,
//    ram_din=pattern(a) (inverted if latched). After a=DEPTH-1, go to READ at a=0.
//  - READ: one read per cycle for a=0..DEPTH-1, with ram_select=1, ram_write=0.
//    The expected value and address are delayed RD_LAT cycles through a shift
//    pipeline and compared with ram_dout.
//  - DRAIN: RD_LAT cycles with ram_select=0, so in-flight compares complete.
//    With RD_LAT=0 this state is skipped.
//  - DONE: done=1 for exactly one cycle, pass=(err_count==0); then go to IDLE.
//  - Timing: with start sampled at edge 0, FILL covers cycles 1..DEPTH, READ
//    covers DEPTH+1..2*DEPTH, and done is high in cycle 2*DEPTH+RD_LAT+1.
//  - Miscompare handling: increment err_count unless it is already 255. Capture
//    fail_addr only on the first miscompare of a run.
//  - Address wrap: the address counter is AW+1 bits wide; the phase ends on
//    terminal count, not on wrap to 0.
//  - start while busy: ignored; no restart and no effect on results.
//  - pass, fail_addr and err_count hold their values after done until the next
//    accepted start.
// TESTING
//  1 Fault-free RAM model, DEPTH=1024, invert=0 -> at address 200, ram_din=144;
//    done in cycle 2050; pass=1; err_count=0.
//  2 Same run with invert=1 -> at address 200, ram_din=111 (~144); pass=1.
//  3 Model forces bit0 of the read at addresses 7, 300 and 1023 -> pass=0;
//    fail_addr=7; err_count=3.
//  4 Model corrupts every read -> err_count=255 (saturated); fail_addr=0.
//  5 start re-pulsed at cycle 500 -> ignored; done still in cycle 2050.
//  6 rst_n low during FILL at address 100 -> all outputs 0 asynchronously; new
//    start -> full clean pass.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// Self-test controller for a single-port RAM: writes a pattern to every location,
// reads it all back, compares, and reports pass, first failing address and error count.
module ram_bist_ctrl #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int SEED   = 0,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_invert,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_din,
  output logic          o_ram_write,
  output logic          o_ram_select,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_fail_addr,
  output logic [7:0]    o_err_count
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int          PW         = (AW + 1 > DW) ? AW + 1 : DW;
  localparam logic [AW:0] LAST       = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] DRAIN_LAST = (AW+1)'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t        r_state, w_nxt_state;
  logic [AW:0]   r_addr, w_nxt_addr;
  logic          r_inv;
  logic          w_rd;
  logic [PW-1:0] w_pat_sum;
  logic [DW-1:0] w_pat;
  logic          w_cmp_vld;
  logic [DW-1:0] w_cmp_exp;
  logic [AW-1:0] w_cmp_adr;
  logic          w_err_hit;

  assign w_pat_sum = PW'({r_addr[AW-1:0], 1'b0}) + PW'(SEED);
  assign w_pat     = w_pat_sum[DW-1:0] ^ {DW{r_inv}};
  assign w_err_hit = w_cmp_vld && (i_ram_dout != w_cmp_exp);

  // Expected data/address ride alongside the read so they line up with i_ram_dout.
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign w_cmp_vld = w_rd;
      assign w_cmp_exp = w_pat;
      assign w_cmp_adr = r_addr[AW-1:0];
    end else begin : g_lat
      logic [RD_LAT:1]         r_vld_pipe;
      logic [RD_LAT:1][DW-1:0] r_exp_pipe;
      logic [RD_LAT:1][AW-1:0] r_adr_pipe;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vld_pipe <= '0;
          r_exp_pipe <= '0;
          r_adr_pipe <= '0;
        end else begin
          r_vld_pipe[1] <= w_rd;
          r_exp_pipe[1] <= w_pat;
          r_adr_pipe[1] <= r_addr[AW-1:0];
          for (int i = 2; i <= RD_LAT; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_exp_pipe[i] <= r_exp_pipe[i-1];
            r_adr_pipe[i] <= r_adr_pipe[i-1];
          end
        end
      end
      assign w_cmp_vld = r_vld_pipe[RD_LAT];
      assign w_cmp_exp = r_exp_pipe[RD_LAT];
      assign w_cmp_adr = r_adr_pipe[RD_LAT];
    end
  endgenerate

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_addr   = r_addr;
    o_ram_select = 1'b0;
    o_ram_write  = 1'b0;
    o_ram_addr   = '0;
    o_ram_din    = '0;
    o_done       = 1'b0;
    w_rd         = 1'b0;
    o_busy       = (r_state == S_FILL) || (r_state == S_READ) || (r_state == S_DRAIN);
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt_state = S_FILL;
          w_nxt_addr  = '0;
        end
      end
      S_FILL: begin
        o_ram_select = 1'b1;
        o_ram_write  = 1'b1;
        o_ram_addr   = r_addr[AW-1:0];
        o_ram_din    = w_pat;
        if (r_addr == LAST) begin
          w_nxt_state = S_READ;
          w_nxt_addr  = '0;
        end else begin
          w_nxt_addr = r_addr + 1'b1;
        end
      end
      S_READ: begin
        o_ram_select = 1'b1;
        o_ram_addr   = r_addr[AW-1:0];
        w_rd         = 1'b1;
        if (r_addr == LAST) begin
          w_nxt_state = (RD_LAT == 0) ? S_DONE : S_DRAIN;
          w_nxt_addr  = '0;
        end else begin
          w_nxt_addr = r_addr + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_addr == DRAIN_LAST) begin
          w_nxt_state = S_DONE;
          w_nxt_addr  = '0;
        end else begin
          w_nxt_addr = r_addr + 1'b1;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_inv       <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_addr <= '0;
      o_err_count <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_addr  <= w_nxt_addr;
      if (r_state == S_IDLE && i_start) begin
        r_inv       <= i_invert;
        o_pass      <= 1'b0;
        o_fail_addr <= '0;
        o_err_count <= '0;
      end else if (w_err_hit) begin
        if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
        if (o_err_count == 8'd0)  o_fail_addr <= w_cmp_adr;
      end
      // Last compare may land on the same edge, so fold it into the verdict.
      if (w_nxt_state == S_DONE && r_state != S_DONE)
        o_pass <= (o_err_count == 8'd0) && !w_err_hit;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM model with injectable read faults, randomized runs
// checked against expectations derived from the fault map and the pattern formula.
module tb_ram_bist_ctrl;
  localparam int AW = 10, DW = 8, SEED = 0, DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          invert = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_write, ram_select;
  logic [DW-1:0] ram_dout = '0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [7:0]    err_count;

  logic [DW-1:0] mem [DEPTH];
  bit            flip [DEPTH];

  int n_chk = 0, n_err = 0;
  int done_cyc, din200, wr_bad, wr_idx;

  ram_bist_ctrl #(.AW(AW), .DW(DW), .SEED(SEED), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_invert(invert),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din), .o_ram_write(ram_write),
    .o_ram_select(ram_select), .i_ram_dout(ram_dout), .o_busy(busy),
    .o_done(done), .o_pass(pass), .o_fail_addr(fail_addr), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  // One-cycle read latency RAM; faulty locations return bit0 flipped.
  always @(posedge clk) begin
    if (ram_select) begin
      if (ram_write) mem[ram_addr] <= ram_din;
      else           ram_dout <= mem[ram_addr] ^ {7'b0, flip[ram_addr]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pat(input int a, input bit inv);
    int p;
    p = (2 * a + SEED) % (1 << DW);
    return inv ? (p ^ ((1 << DW) - 1)) : p;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) flip[i] = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_sel"},  ram_select, 0);
    chk({tag, "_wr"},   ram_write, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_din"},  ram_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail_addr, 0);
    chk({tag, "_errc"}, err_count, 0);
  endtask

  // Starts a run (start sampled at edge 0) and follows it cycle by cycle.
  task automatic run(input bit inv, input int abort_at, input bit repulse);
    done_cyc = -1; din200 = -1; wr_bad = 0; wr_idx = 0;
    @(negedge clk);
    start = 1'b1; invert = inv;
    @(posedge clk);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (repulse && cyc == 500) begin start = 1'b1; invert = ~inv; end
      if (repulse && cyc == 501) start = 1'b0;
      if (cyc == 1000) chk("busy_mid", busy, 1);
      if (ram_select && ram_write) begin
        if (ram_addr != AW'(wr_idx) || int'(ram_din) != pat(wr_idx, inv)) wr_bad++;
        if (ram_addr == 200) din200 = ram_din;
        wr_idx++;
      end
      if (cyc == abort_at) begin
        chk("pre_abort_addr", ram_addr, abort_at - 1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("done_cyc", done_cyc, 2 * DEPTH + 2);
    chk("wr_count", wr_idx, DEPTH);
    chk("wr_bad", wr_bad, 0);
  endtask

  // Expected verdict is derived directly from the fault map.
  task automatic chk_results(input string tag);
    int n, first, exp_err;
    n = 0; first = 0;
    for (int a = DEPTH - 1; a >= 0; a--) if (flip[a]) begin n++; first = a; end
    exp_err = (n > 255) ? 255 : n;
    chk({tag, "_pass"}, pass, (n == 0));
    chk({tag, "_fail"}, fail_addr, first);
    chk({tag, "_errc"}, err_count, exp_err);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_pass_hold"}, pass, (n == 0));
    chk({tag, "_errc_hold"}, err_count, exp_err);
  endtask

  initial begin
    clear_faults();
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    run(1'b0, 0, 1'b0);
    chk("t1_din200", din200, 144);
    chk_results("t1");

    run(1'b1, 0, 1'b0);
    chk("t2_din200", din200, 111);
    chk_results("t2");

    flip[7] = 1'b1; flip[300] = 1'b1; flip[1023] = 1'b1;
    run(1'b0, 0, 1'b0);
    chk_results("t3");

    for (int i = 0; i < DEPTH; i++) flip[i] = 1'b1;
    run(1'b0, 0, 1'b0);
    chk_results("t4");

    clear_faults();
    run(1'b0, 0, 1'b1);
    chk("t5_din200", din200, 144);
    chk_results("t5");

    for (int r = 0; r < 4; r++) begin
      bit inv;
      int nf;
      clear_faults();
      inv = 1'($urandom_range(0, 1));
      nf = (r == 3) ? $urandom_range(256, 400) : $urandom_range(0, 6);
      for (int k = 0; k < nf; k++) flip[$urandom_range(0, DEPTH - 1)] = 1'b1;
      run(inv, 0, 1'($urandom_range(0, 1)));
      chk("rnd_din200", din200, pat(200, inv));
      chk_results("rnd");
    end

    clear_faults();
    flip[5] = 1'b1;
    run(1'b0, 101, 1'b0);
    @(negedge clk);
    chk_idle_zero("post_abort");
    clear_faults();
    run(1'b0, 0, 1'b0);
    chk_results("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
